// File: rtl/mem_io_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_io_ctrl : 256x16 RAM, LED register and synchronised switch port behind
//               the core's mem_cmd bus, with ready handshake and sticky error.
// Revision    : 1.0
// ----------------------------------------------------------------------------
module mem_io_ctrl #(
  parameter int                DATA_W    = 16,
  parameter int                ADDR_W    = 9,
  parameter int                RAM_WORDS = 256,
  parameter logic [ADDR_W-1:0] LED_ADDR  = 9'h100,
  parameter logic [ADDR_W-1:0] SW_ADDR   = 9'h140
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        mem_cmd,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] din,
  input  logic [7:0]        sw,
  output logic [DATA_W-1:0] mdata,
  output logic [7:0]        led,
  output logic              mem_ready,
  output logic              err
);

  localparam int                RAM_AW    = $clog2(RAM_WORDS);
  localparam logic [ADDR_W-1:0] RAM_LIMIT = ADDR_W'(RAM_WORDS);

  localparam logic [1:0] CMD_NONE  = 2'b00;
  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RVALID = 2'd1;
  localparam logic [1:0] S_WDONE  = 2'd2;

  logic [DATA_W-1:0] ram [RAM_WORDS];

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] mdata_q, mdata_d;
  logic [7:0]        led_q, led_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] last_addr_q, last_addr_d;
  logic [7:0]        sw_sync1_q, sw_sync1_d;
  logic [7:0]        sw_sync2_q, sw_sync2_d;

  logic              hit_ram, hit_led, hit_sw;
  logic [RAM_AW-1:0] ram_idx;
  logic              ram_we;

  always_comb begin
    hit_ram     = (mem_addr < RAM_LIMIT);
    hit_led     = (mem_addr == LED_ADDR);
    hit_sw      = (mem_addr == SW_ADDR);
    ram_idx     = mem_addr[RAM_AW-1:0];
    ram_we      = 1'b0;
    state_d     = state_q;
    mdata_d     = mdata_q;
    led_d       = led_q;
    ready_d     = ready_q;
    err_d       = err_q;
    last_addr_d = last_addr_q;
    sw_sync1_d  = sw;
    sw_sync2_d  = sw_sync1_q;

    case (mem_cmd)
      CMD_READ: begin
        if (hit_ram) begin
          mdata_d = ram[ram_idx];
        end else if (hit_sw) begin
          mdata_d = {{(DATA_W-8){1'b0}}, sw_sync2_q};
        end else begin
          mdata_d = '0;
          err_d   = 1'b1;
        end
        // An address change inside a read burst costs one not-ready cycle.
        ready_d     = (state_q != S_RVALID) || (mem_addr == last_addr_q);
        last_addr_d = mem_addr;
        state_d     = S_RVALID;
      end
      CMD_WRITE: begin
        if (hit_ram) begin
          ram_we  = 1'b1;
          ready_d = 1'b1;
          state_d = S_WDONE;
        end else if (hit_led) begin
          led_d   = din[7:0];
          ready_d = 1'b1;
          state_d = S_WDONE;
        end else begin
          err_d = 1'b1;
        end
      end
      CMD_NONE: begin
        ready_d = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        ready_d = 1'b0;
        err_d   = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      mdata_q     <= '0;
      led_q       <= '0;
      ready_q     <= 1'b0;
      err_q       <= 1'b0;
      last_addr_q <= '0;
      sw_sync1_q  <= '0;
      sw_sync2_q  <= '0;
    end else begin
      state_q     <= state_d;
      mdata_q     <= mdata_d;
      led_q       <= led_d;
      ready_q     <= ready_d;
      err_q       <= err_d;
      last_addr_q <= last_addr_d;
      sw_sync1_q  <= sw_sync1_d;
      sw_sync2_q  <= sw_sync2_d;
    end
  end

  // RAM is never cleared; gating on reset keeps an aborted access from writing.
  always_ff @(posedge clk) begin
    if (reset && ram_we) begin
      ram[ram_idx] <= din;
    end
  end

  assign mdata     = mdata_q;
  assign led       = led_q;
  assign mem_ready = ready_q;
  assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_io_ctrl.sv
`default_nettype none
// tb_mem_io_ctrl : randomized bench with a behavioural model of the memory map,
//                  plus directed cases with hand-computed expectations.
module tb_mem_io_ctrl;

  localparam logic [1:0] C_NONE  = 2'b00;
  localparam logic [1:0] C_READ  = 2'b01;
  localparam logic [1:0] C_WRITE = 2'b10;
  localparam logic [1:0] C_ILL   = 2'b11;
  localparam logic [8:0] LED_A   = 9'h100;
  localparam logic [8:0] SW_A    = 9'h140;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  mem_cmd = C_NONE;
  logic [8:0]  mem_addr = '0;
  logic [15:0] din = '0;
  logic [7:0]  sw = '0;
  logic [15:0] mdata;
  logic [7:0]  led;
  logic        mem_ready;
  logic        err;

  mem_io_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .mem_cmd   (mem_cmd),
    .mem_addr  (mem_addr),
    .din       (din),
    .sw        (sw),
    .mdata     (mdata),
    .led       (led),
    .mem_ready (mem_ready),
    .err       (err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit check_en = 1'b0;

  // Model: memory map contents plus "are we inside a read burst, and at which address".
  logic [15:0] m_ram [256];
  logic [15:0] m_mdata;
  logic [7:0]  m_led;
  logic        m_ready;
  logic        m_err;
  logic [7:0]  m_s1, m_s2;
  bit          m_in_read;
  logic [8:0]  m_last;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mdata   = '0;
    m_led     = '0;
    m_ready   = 1'b0;
    m_err     = 1'b0;
    m_s1      = '0;
    m_s2      = '0;
    m_in_read = 1'b0;
    m_last    = '0;
  endtask

  task automatic model_step();
    logic [7:0] sw_seen;
    sw_seen = m_s2;
    m_s2 = m_s1;
    m_s1 = sw;
    if (mem_cmd == C_READ) begin
      if (mem_addr < 9'd256)     m_mdata = m_ram[mem_addr[7:0]];
      else if (mem_addr == SW_A) m_mdata = {8'h00, sw_seen};
      else begin
        m_mdata = 16'h0000;
        m_err   = 1'b1;
      end
      m_ready   = !(m_in_read && (mem_addr != m_last));
      m_in_read = 1'b1;
      m_last    = mem_addr;
    end else if (mem_cmd == C_WRITE) begin
      if (mem_addr < 9'd256) begin
        m_ram[mem_addr[7:0]] = din;
        m_ready   = 1'b1;
        m_in_read = 1'b0;
      end else if (mem_addr == LED_A) begin
        m_led     = din[7:0];
        m_ready   = 1'b1;
        m_in_read = 1'b0;
      end else begin
        m_err = 1'b1;
      end
    end else begin
      m_ready   = 1'b0;
      m_in_read = 1'b0;
      if (mem_cmd == C_ILL) m_err = 1'b1;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) model_reset();
      else        model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (check_en) begin
        chk("mdata", 32'(mdata), 32'(m_mdata));
        chk("led", 32'(led), 32'(m_led));
        chk("mem_ready", 32'(mem_ready), 32'(m_ready));
        chk("err", 32'(err), 32'(m_err));
      end
    end
  end

  task automatic cyc(input logic [1:0] c, input logic [8:0] a, input logic [15:0] d);
    mem_cmd  = c;
    mem_addr = a;
    din      = d;
    @(posedge clk);
    #2;
  endtask

  initial begin
    int r;
    logic [1:0] rc;
    logic [8:0] ra;
    rc = C_NONE;
    ra = '0;

    #1 reset = 1'b0;
    check_en = 1'b1;
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;

    for (int i = 0; i < 256; i++) cyc(C_WRITE, 9'(i), 16'($urandom));
    cyc(C_NONE, 9'h000, 16'h0000);

    // Reset in the middle of a read burst, with led and err previously set.
    cyc(C_WRITE, LED_A, 16'h00FF);
    cyc(C_ILL, 9'h000, 16'h0000);
    cyc(C_READ, 9'h005, 16'h0000);
    cyc(C_READ, 9'h005, 16'h0000);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    chk("rst_mdata", 32'(mdata), 32'h0);
    chk("rst_led", 32'(led), 32'h0);
    chk("rst_ready", 32'(mem_ready), 32'h0);
    chk("rst_err", 32'(err), 32'h0);

    cyc(C_WRITE, 9'h005, 16'hBEEF);
    cyc(C_READ, 9'h005, 16'h0000);
    chk("raw_mdata", 32'(mdata), 32'hBEEF);
    chk("raw_ready", 32'(mem_ready), 32'h1);

    cyc(C_WRITE, 9'h000, 16'hD0A5);
    cyc(C_WRITE, 9'h001, 16'hC0E0);
    cyc(C_READ, 9'h000, 16'h0000);
    chk("fetch0_mdata", 32'(mdata), 32'hD0A5);
    chk("fetch0_ready", 32'(mem_ready), 32'h1);
    cyc(C_READ, 9'h000, 16'h0000);
    chk("fetch0_hold_ready", 32'(mem_ready), 32'h1);
    cyc(C_READ, 9'h001, 16'h0000);
    chk("fetch1_mdata", 32'(mdata), 32'hC0E0);
    chk("fetch1_ready_drop", 32'(mem_ready), 32'h0);
    cyc(C_READ, 9'h001, 16'h0000);
    chk("fetch1_ready", 32'(mem_ready), 32'h1);

    cyc(C_WRITE, LED_A, 16'h12A5);
    chk("led_write", 32'(led), 32'hA5);
    sw = 8'h3C;
    repeat (3) cyc(C_NONE, 9'h000, 16'h0000);
    cyc(C_READ, SW_A, 16'h0000);
    chk("sw_read", 32'(mdata), 32'h003C);

    cyc(C_READ, 9'h1FF, 16'h0000);
    chk("unmapped_mdata", 32'(mdata), 32'h0);
    chk("unmapped_err", 32'(err), 32'h1);
    cyc(C_READ, 9'h005, 16'h0000);
    chk("after_unmapped_mdata", 32'(mdata), 32'hBEEF);
    chk("err_sticky", 32'(err), 32'h1);

    cyc(C_ILL, 9'h005, 16'h0000);
    chk("illegal_err", 32'(err), 32'h1);
    cyc(C_READ, 9'h005, 16'h0000);
    chk("illegal_nowrite", 32'(mdata), 32'hBEEF);

    reset = 1'b0;
    #1;
    chk("async_err", 32'(err), 32'h0);
    chk("async_ready", 32'(mem_ready), 32'h0);
    @(posedge clk);
    #2 reset = 1'b1;

    for (int i = 0; i < 800; i++) begin
      r = $urandom_range(0, 99);
      if (r >= 25) begin
        r = $urandom_range(0, 99);
        if (r < 40)      rc = C_READ;
        else if (r < 75) rc = C_WRITE;
        else if (r < 93) rc = C_NONE;
        else             rc = C_ILL;
        r = $urandom_range(0, 99);
        if (r < 55)      ra = 9'($urandom_range(0, 7));
        else if (r < 75) ra = 9'($urandom_range(0, 255));
        else if (r < 83) ra = LED_A;
        else if (r < 91) ra = SW_A;
        else             ra = 9'($urandom_range(256, 511));
      end
      if ($urandom_range(0, 9) == 0) sw = 8'($urandom);
      if ($urandom_range(0, 99) < 2) begin
        reset = 1'b0;
        @(posedge clk);
        #2 reset = 1'b1;
      end
      cyc(rc, ra, 16'($urandom));
    end

    cyc(C_NONE, 9'h000, 16'h0000);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
